// File: rtl/dark_channel_win3.sv
// Streaming 3x3 dark-channel filter: per-pixel min(R,G,B) followed by a 3x3 minimum,
// with out-of-image neighbours treated as 8'hFF and an internal flush to drain the last rows.
module dark_channel_win3 #(
    parameter int unsigned IMG_W      = 480,
    parameter int unsigned IMG_H      = 270,
    parameter int unsigned ADDR_WIDTH = 17,
    parameter int unsigned DATA_WIDTH = 24
) (
    input  logic                  clk_100M,
    input  logic                  reset,
    input  logic                  pix_valid,
    input  logic [ADDR_WIDTH-1:0] pix_addr,
    input  logic [DATA_WIDTH-1:0] pix_din,
    output logic                  dc_valid,
    output logic [ADDR_WIDTH-1:0] dc_addr,
    output logic [7:0]            dc_data,
    output logic                  frame_done,
    output logic                  overrun
);

    localparam int unsigned COL_W     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned ROW_W     = $clog2(IMG_H + 2);
    localparam int unsigned FL_W      = $clog2(IMG_W + 2);
    localparam int unsigned LAST_ADDR = IMG_W * IMG_H - 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

    function automatic logic [7:0] min2(input logic [7:0] a, input logic [7:0] b);
        return (a < b) ? a : b;
    endfunction

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] exp_addr_q, exp_addr_d;
    logic [FL_W-1:0]       flush_cnt_q, flush_cnt_d;
    logic                  overrun_q, overrun_d;

    logic start_c, restart_c, acc_c, inject_c, load_c;
    logic primed_c, emit_c, last_emit_c;
    logic [7:0] pix_min_c;

    // stage-1 pixel and its position, plus the position of the next pixel to enter
    logic             s1_valid_q;
    logic [7:0]       m_q;
    logic [COL_W-1:0] s1_col_q, in_col_q, in_col_d, base_col_c;
    logic [ROW_W-1:0] s1_row_q, in_row_q, in_row_d, base_row_c;

    logic [7:0] lb_a [IMG_W];
    logic [7:0] lb_b [IMG_W];
    logic [7:0] wl_t_q, wl_m_q, wl_b_q, wc_t_q, wc_m_q, wc_b_q;
    logic [7:0] cur_t_c, cur_m_c, cur_b_c, dc_min_c;

    logic [COL_W-1:0]      cc_q;
    logic [ROW_W-1:0]      cr_q;
    logic [ADDR_WIDTH-1:0] caddr_q;

    logic                  dc_valid_q, frame_done_q;
    logic [ADDR_WIDTH-1:0] dc_addr_q;
    logic [7:0]            dc_data_q;

    // a pixel at address 0 always opens a new frame, abandoning any frame in progress
    always_comb begin
        start_c   = pix_valid && (pix_addr == '0);
        restart_c = start_c && (state_q != S_IDLE);
        acc_c     = start_c || (pix_valid && (state_q == S_RUN));
        inject_c  = (state_q == S_FLUSH) && !start_c && (flush_cnt_q != FL_W'(IMG_W + 1));
        load_c    = acc_c || inject_c;
        pix_min_c = min2(min2(pix_din[23:16], pix_din[15:8]), pix_din[7:0]);
    end

    always_ff @(posedge clk_100M) begin
        if (reset) begin
            state_q     <= S_IDLE;
            exp_addr_q  <= '0;
            flush_cnt_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            exp_addr_q  <= exp_addr_d;
            flush_cnt_q <= flush_cnt_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        exp_addr_d  = exp_addr_q;
        flush_cnt_d = flush_cnt_q;
        overrun_d   = overrun_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_c) begin
                    state_d    = S_RUN;
                    exp_addr_d = ADDR_WIDTH'(1);
                end
            end
            S_RUN: begin
                if (start_c) begin
                    exp_addr_d = ADDR_WIDTH'(1);
                end else if (pix_valid) begin
                    if (pix_addr != exp_addr_q) overrun_d = 1'b1;
                    if (exp_addr_q == ADDR_WIDTH'(LAST_ADDR)) begin
                        state_d     = S_FLUSH;
                        flush_cnt_d = '0;
                    end else begin
                        exp_addr_d = exp_addr_q + ADDR_WIDTH'(1);
                    end
                end
            end
            S_FLUSH: begin
                if (pix_valid) overrun_d = 1'b1;
                if (start_c) begin
                    state_d    = S_RUN;
                    exp_addr_d = ADDR_WIDTH'(1);
                end else begin
                    if (inject_c) flush_cnt_d = flush_cnt_q + FL_W'(1);
                    if (last_emit_c) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        base_col_c = start_c ? '0 : in_col_q;
        base_row_c = start_c ? '0 : in_row_q;
        in_col_d   = in_col_q;
        in_row_d   = in_row_q;
        if (load_c) begin
            if (base_col_c == COL_W'(IMG_W - 1)) begin
                in_col_d = '0;
                in_row_d = base_row_c + ROW_W'(1);
            end else begin
                in_col_d = base_col_c + COL_W'(1);
                in_row_d = base_row_c;
            end
        end
    end

    always_ff @(posedge clk_100M) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            m_q        <= '0;
            s1_col_q   <= '0;
            s1_row_q   <= '0;
            in_col_q   <= '0;
            in_row_q   <= '0;
        end else begin
            s1_valid_q <= load_c;
            in_col_q   <= in_col_d;
            in_row_q   <= in_row_d;
            if (load_c) begin
                m_q      <= acc_c ? pix_min_c : 8'hFF;
                s1_col_q <= base_col_c;
                s1_row_q <= base_row_c;
            end
        end
    end

    always_ff @(posedge clk_100M) begin
        if (s1_valid_q) begin
            lb_a[s1_col_q] <= m_q;
            lb_b[s1_col_q] <= lb_a[s1_col_q];
        end
    end

    // current column is {p-2W, p-W, p}; window columns hold p-1 (centre) and p-2 (left)
    always_comb begin
        cur_t_c = lb_b[s1_col_q];
        cur_m_c = lb_a[s1_col_q];
        cur_b_c = m_q;
    end

    always_ff @(posedge clk_100M) begin
        if (reset || start_c) begin
            wl_t_q <= '0; wl_m_q <= '0; wl_b_q <= '0;
            wc_t_q <= '0; wc_m_q <= '0; wc_b_q <= '0;
        end else if (s1_valid_q) begin
            wl_t_q <= wc_t_q;  wl_m_q <= wc_m_q;  wl_b_q <= wc_b_q;
            wc_t_q <= cur_t_c; wc_m_q <= cur_m_c; wc_b_q <= cur_b_c;
        end
    end

    always_comb begin
        primed_c    = (s1_row_q > ROW_W'(1)) || ((s1_row_q == ROW_W'(1)) && (s1_col_q != '0));
        emit_c      = s1_valid_q && primed_c && !restart_c;
        last_emit_c = emit_c && (caddr_q == ADDR_WIDTH'(LAST_ADDR));
    end

    // skipping masked neighbours is equivalent to substituting 8'hFF for them
    always_comb begin
        dc_min_c = wc_m_q;
        if (cr_q != '0)                 dc_min_c = min2(dc_min_c, wc_t_q);
        if (cr_q != ROW_W'(IMG_H - 1))  dc_min_c = min2(dc_min_c, wc_b_q);
        if (cc_q != '0) begin
            dc_min_c = min2(dc_min_c, wl_m_q);
            if (cr_q != '0)                dc_min_c = min2(dc_min_c, wl_t_q);
            if (cr_q != ROW_W'(IMG_H - 1)) dc_min_c = min2(dc_min_c, wl_b_q);
        end
        if (cc_q != COL_W'(IMG_W - 1)) begin
            dc_min_c = min2(dc_min_c, cur_m_c);
            if (cr_q != '0)                dc_min_c = min2(dc_min_c, cur_t_c);
            if (cr_q != ROW_W'(IMG_H - 1)) dc_min_c = min2(dc_min_c, cur_b_c);
        end
    end

    always_ff @(posedge clk_100M) begin
        if (reset || start_c) begin
            cc_q    <= '0;
            cr_q    <= '0;
            caddr_q <= '0;
        end else if (emit_c) begin
            caddr_q <= caddr_q + ADDR_WIDTH'(1);
            if (cc_q == COL_W'(IMG_W - 1)) begin
                cc_q <= '0;
                cr_q <= cr_q + ROW_W'(1);
            end else begin
                cc_q <= cc_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk_100M) begin
        if (reset) begin
            dc_valid_q   <= 1'b0;
            frame_done_q <= 1'b0;
            dc_addr_q    <= '0;
            dc_data_q    <= '0;
        end else begin
            dc_valid_q   <= emit_c;
            frame_done_q <= last_emit_c;
            if (emit_c) begin
                dc_addr_q <= caddr_q;
                dc_data_q <= dc_min_c;
            end
        end
    end

    assign dc_valid   = dc_valid_q;
    assign dc_addr    = dc_addr_q;
    assign dc_data    = dc_data_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_dark_channel_win3.sv
// Scoreboard bench for dark_channel_win3 on a reduced 8x6 image.
module tb_dark_channel_win3;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int N  = W * H;
    localparam int AW = 17;

    logic          clk = 1'b0;
    logic          reset;
    logic          pix_valid;
    logic [AW-1:0] pix_addr;
    logic [23:0]   pix_din;
    logic          dc_valid;
    logic [AW-1:0] dc_addr;
    logic [7:0]    dc_data;
    logic          frame_done;
    logic          overrun;

    dark_channel_win3 #(.IMG_W(W), .IMG_H(H), .ADDR_WIDTH(AW), .DATA_WIDTH(24)) dut (
        .clk_100M(clk), .reset(reset), .pix_valid(pix_valid), .pix_addr(pix_addr),
        .pix_din(pix_din), .dc_valid(dc_valid), .dc_addr(dc_addr), .dc_data(dc_data),
        .frame_done(frame_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         addr;
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [23:0] img[N];
    int checks = 0, failures = 0;
    int cyc = 0, fd_count = 0, fd_cyc = 0, first_cyc = 0;
    int acc_first_cyc = 0, last_drive_cyc = 0, out_cnt = 0, low_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] pmin(input logic [23:0] p);
        logic [7:0] m;
        m = p[23:16];
        if (p[15:8] < m) m = p[15:8];
        if (p[7:0] < m) m = p[7:0];
        return m;
    endfunction

    function automatic logic [7:0] golden(input int q);
        int r, c;
        logic [7:0] mn, v;
        r = q / W;
        c = q % W;
        mn = 8'hFF;
        for (int dr = -1; dr <= 1; dr++)
            for (int dcol = -1; dcol <= 1; dcol++)
                if (r + dr >= 0 && r + dr < H && c + dcol >= 0 && c + dcol < W) begin
                    v = pmin(img[(r + dr) * W + c + dcol]);
                    if (v < mn) mn = v;
                end
        return mn;
    endfunction

    task automatic push_exp(input int q);
        exp_t e;
        e.addr = q;
        e.data = golden(q);
        e.last = (q == N - 1);
        sb.push_back(e);
    endtask

    // every output is checked against the oldest outstanding expectation
    always @(negedge clk) begin
        if (dc_valid) begin
            out_cnt++;
            if (dc_data == 8'h10) low_cnt++;
            if (dc_addr == '0) first_cyc = cyc;
            if (frame_done) begin
                fd_count++;
                fd_cyc = cyc;
            end
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output got addr=%0d data=%02h exp=none", dc_addr, dc_data);
            end else begin
                mon_e = sb.pop_front();
                if (dc_addr !== AW'(mon_e.addr) || dc_data !== mon_e.data || frame_done !== mon_e.last) begin
                    failures++;
                    $display("FAIL dc_output got addr=%0d data=%02h fd=%0b exp addr=%0d data=%02h fd=%0b",
                             dc_addr, dc_data, frame_done, mon_e.addr, mon_e.data, mon_e.last);
                end
            end
        end
    end

    // gap < 0 picks a random 0..2 idle cycles after the pixel
    task automatic send_pixel(input int a, input int addr, input int gap, input bit push);
        int g;
        @(negedge clk);
        pix_valid = 1'b1;
        pix_addr  = AW'(addr);
        pix_din   = img[a];
        if (a == W + 1) acc_first_cyc = cyc;
        if (a == N - 1) last_drive_cyc = cyc;
        if (push && a >= W + 1) push_exp(a - W - 1);
        if (push && a == N - 1)
            for (int q = N - W - 1; q < N; q++) push_exp(q);
        g = (gap < 0) ? int'($urandom_range(2, 0)) : gap;
        for (int i = 0; i < g; i++) begin
            @(negedge clk);
            pix_valid = 1'b0;
        end
    endtask

    task automatic wait_drain(input string name);
        int i;
        i = 0;
        while (sb.size() != 0 && i < 200) begin
            @(negedge clk);
            i++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s pending=%0d exp=0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic run_frame(input int gap, input int bad_at, input bit poke);
        for (int a = 0; a < N; a++) send_pixel(a, (a == bad_at) ? a + 3 : a, gap, 1'b1);
        @(negedge clk);
        pix_valid = poke;
        pix_addr  = AW'(5);
        @(negedge clk);
        pix_valid = 1'b0;
        wait_drain("frame_drain");
    endtask

    task automatic test_reset;
        reset = 1'b1;
        pix_valid = 1'b0;
        pix_addr = '0;
        pix_din = '0;
        repeat (3) @(negedge clk);
        checks++; if (dc_valid !== 1'b0) begin failures++; $display("FAIL reset_dc_valid got=%0b exp=0", dc_valid); end
        checks++; if (dc_addr !== '0) begin failures++; $display("FAIL reset_dc_addr got=%0d exp=0", dc_addr); end
        checks++; if (dc_data !== 8'h00) begin failures++; $display("FAIL reset_dc_data got=%02h exp=00", dc_data); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%0b exp=0", frame_done); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%0b exp=0", overrun); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_uniform;
        int fd0;
        fd0 = fd_count;
        for (int i = 0; i < N; i++) img[i] = 24'h405080;
        run_frame(0, -1, 1'b0);
        checks++; if (fd_count - fd0 !== 1) begin failures++; $display("FAIL uniform_frame_done got=%0d exp=1", fd_count - fd0); end
        checks++; if (first_cyc - acc_first_cyc !== 2) begin failures++; $display("FAIL first_latency got=%0d exp=2", first_cyc - acc_first_cyc); end
        checks++; if (fd_cyc - last_drive_cyc !== W + 3) begin failures++; $display("FAIL done_latency got=%0d exp=%0d", fd_cyc - last_drive_cyc, W + 3); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL uniform_overrun got=%0b exp=0", overrun); end
    endtask

    task automatic test_dark_pixel;
        int l0;
        l0 = low_cnt;
        for (int i = 0; i < N; i++) img[i] = 24'hFFFFFF;
        img[2 * W + 3] = 24'h201030;
        run_frame(0, -1, 1'b0);
        checks++; if (low_cnt - l0 !== 9) begin failures++; $display("FAIL dark_count got=%0d exp=9", low_cnt - l0); end
    endtask

    task automatic test_edge_wrap;
        int l0;
        l0 = low_cnt;
        for (int i = 0; i < N; i++) img[i] = 24'hFFFFFF;
        img[W - 1] = 24'h302010;
        run_frame(2, -1, 1'b0);
        checks++; if (low_cnt - l0 !== 4) begin failures++; $display("FAIL edge_count got=%0d exp=4", low_cnt - l0); end
    endtask

    task automatic test_random;
        int fd0;
        fd0 = fd_count;
        for (int i = 0; i < N; i++) img[i] = 24'($urandom);
        run_frame(-1, -1, 1'b0);
        checks++; if (fd_count - fd0 !== 1) begin failures++; $display("FAIL random_frame_done got=%0d exp=1", fd_count - fd0); end
    endtask

    task automatic test_restart;
        int fd0, o0;
        fd0 = fd_count;
        o0 = out_cnt;
        for (int i = 0; i < N; i++) img[i] = 24'($urandom);
        for (int a = 0; a <= 20; a++) send_pixel(a, a, 0, 1'b1);
        @(negedge clk);
        pix_valid = 1'b0;
        wait_drain("restart_old_drain");
        for (int i = 0; i < N; i++) img[i] = 24'($urandom);
        run_frame(0, -1, 1'b0);
        checks++; if (fd_count - fd0 !== 1) begin failures++; $display("FAIL restart_frame_done got=%0d exp=1", fd_count - fd0); end
        checks++; if (out_cnt - o0 !== 20 - W + N) begin failures++; $display("FAIL restart_outputs got=%0d exp=%0d", out_cnt - o0, 20 - W + N); end
    endtask

    task automatic test_flush_overrun;
        for (int i = 0; i < N; i++) img[i] = 24'($urandom);
        run_frame(0, -1, 1'b1);
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL flush_overrun got=%0b exp=1", overrun); end
    endtask

    task automatic test_reset_midframe;
        int o0, fd0;
        for (int i = 0; i < N; i++) img[i] = 24'($urandom);
        for (int a = 0; a <= 20; a++) send_pixel(a, a, 0, 1'b1);
        @(negedge clk);
        pix_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        @(negedge clk);
        checks++; if (dc_valid !== 1'b0) begin failures++; $display("FAIL midrst_dc_valid got=%0b exp=0", dc_valid); end
        checks++; if (dc_addr !== '0) begin failures++; $display("FAIL midrst_dc_addr got=%0d exp=0", dc_addr); end
        checks++; if (dc_data !== 8'h00) begin failures++; $display("FAIL midrst_dc_data got=%02h exp=00", dc_data); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL midrst_overrun got=%0b exp=0", overrun); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        o0 = out_cnt;
        for (int a = 21; a <= 25; a++) send_pixel(a, a, 0, 1'b0);
        @(negedge clk);
        pix_valid = 1'b0;
        repeat (6) @(negedge clk);
        checks++; if (out_cnt - o0 !== 0) begin failures++; $display("FAIL idle_after_reset got=%0d exp=0", out_cnt - o0); end
        fd0 = fd_count;
        for (int i = 0; i < N; i++) img[i] = 24'($urandom);
        run_frame(0, 10, 1'b0);
        checks++; if (fd_count - fd0 !== 1) begin failures++; $display("FAIL postrst_frame_done got=%0d exp=1", fd_count - fd0); end
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL mismatch_overrun got=%0b exp=1", overrun); end
    endtask

    initial begin
        reset = 1'b1;
        pix_valid = 1'b0;
        pix_addr = '0;
        pix_din = '0;
        test_reset;
        test_uniform;
        test_dark_pixel;
        test_edge_wrap;
        test_random;
        test_restart;
        test_flush_overrun;
        test_reset_midframe;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
